// File: rtl/vga_sync_compositor_if.sv
// Pixel bus between the VGA timing/compositor block and its renderers and output pins.
// The master modport is the compositor: it produces counters/pins and consumes layer colours.
interface vga_sync_compositor_if;
   logic       pix_tick;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic [7:0] obj1_rgb;
   logic       obj1_on;
   logic [7:0] obj2_rgb;
   logic       obj2_on;
   logic [7:0] bg_rgb;
   logic [2:0] red;
   logic [2:0] green;
   logic [1:0] blue;
   logic       hsync;
   logic       vsync;
   logic       frame_tick;

   modport master (
      output pix_tick, hcount, vcount, red, green, blue, hsync, vsync, frame_tick,
      input  obj1_rgb, obj1_on, obj2_rgb, obj2_on, bg_rgb
   );

   modport slave (
      input  pix_tick, hcount, vcount, red, green, blue, hsync, vsync, frame_tick,
      output obj1_rgb, obj1_on, obj2_rgb, obj2_on, bg_rgb
   );
endinterface

// File: rtl/vga_sync_compositor.sv
// VGA timing generator plus two-layer priority compositor driving 3-3-2 RGB and active-low syncs.
// Outputs trail hcount/vcount by exactly one pixel period, matching the registered renderers.
module vga_sync_compositor #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int PIX_DIV   = 2
) (
   input logic                   clock,
   input logic                   reset,
   vga_sync_compositor_if.master bus
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = $clog2(PIX_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] divCnt;
   logic             pixTick;
   logic [9:0]       hCount;
   logic [9:0]       vCount;
   logic [7:0]       pixelReg;
   logic             hsyncReg;
   logic             vsyncReg;
   logic             videoOn;
   logic             hsNext;
   logic             vsNext;
   logic [7:0]       colourNext;

   assign pixTick = (divCnt == DIV_LAST);

   always_ff @(posedge clock) begin
      if (!reset) begin
         divCnt <= '0;
      end else if (pixTick) begin
         divCnt <= '0;
      end else begin
         divCnt <= divCnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         hCount <= '0;
         vCount <= '0;
      end else if (pixTick) begin
         if (hCount == H_LAST) begin
            hCount <= '0;
            vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
         end else begin
            hCount <= hCount + 10'd1;
         end
      end
   end

   // Decode uses the pre-increment counters so syncs and colour stay aligned one pixel behind.
   always_comb begin
      videoOn    = (hCount < H_VIS) && (vCount < V_VIS);
      hsNext     = !((hCount >= HS_START) && (hCount <= HS_END));
      vsNext     = !((vCount >= VS_START) && (vCount <= VS_END));
      colourNext = 8'h00;
      if (videoOn) begin
         if (bus.obj1_on) begin
            colourNext = bus.obj1_rgb;
         end else if (bus.obj2_on) begin
            colourNext = bus.obj2_rgb;
         end else begin
            colourNext = bus.bg_rgb;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pixelReg <= 8'h00;
         hsyncReg <= 1'b1;
         vsyncReg <= 1'b1;
      end else if (pixTick) begin
         pixelReg <= colourNext;
         hsyncReg <= hsNext;
         vsyncReg <= vsNext;
      end
   end

   assign bus.pix_tick   = pixTick;
   assign bus.hcount     = hCount;
   assign bus.vcount     = vCount;
   assign bus.red        = pixelReg[7:5];
   assign bus.green      = pixelReg[4:2];
   assign bus.blue       = pixelReg[1:0];
   assign bus.hsync      = hsyncReg;
   assign bus.vsync      = vsyncReg;
   assign bus.frame_tick = pixTick && (hCount == H_LAST) && (vCount == V_LAST);

endmodule

// File: tb/tb_vga_sync_compositor.sv
// Directed bench: full-size instance for line timing and compositing, plus a shrunken instance
// whose short frame lets frame_tick and vsync be measured within a small cycle budget.
module tb_vga_sync_compositor;

   logic clock;
   logic reset;
   logic resetS;
   int   compared;
   int   mismatched;

   vga_sync_compositor_if ifc ();
   vga_sync_compositor_if ifcS ();

   vga_sync_compositor dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc.master)
   );

   // Small frame: H_TOTAL=8, V_TOTAL=7, PIX_DIV=3 -> 168 clocks per frame, vsync low on lines 4..5.
   vga_sync_compositor #(
      .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
      .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
      .PIX_DIV   (3)
   ) dutS (
      .clock (clock),
      .reset (resetS),
      .bus   (ifcS.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic o1On, input logic [7:0] o1Rgb,
                                input logic o2On, input logic [7:0] o2Rgb, input logic [7:0] bg);
      ifc.obj1_on  = o1On;
      ifc.obj1_rgb = o1Rgb;
      ifc.obj2_on  = o2On;
      ifc.obj2_rgb = o2Rgb;
      ifc.bg_rgb   = bg;
   endtask

   task automatic waitTick();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!ifc.pix_tick && n < 16);
      if (!ifc.pix_tick) checkOutput("tick_timeout", 32'(ifc.pix_tick), 32'd1);
   endtask

   task automatic gotoPixel(input int h, input int v);
      int n;
      n = 0;
      do begin
         waitTick();
         n++;
      end while (!(ifc.hcount == 10'(h) && ifc.vcount == 10'(v)) && n < 4000);
      checkOutput("goto_h", 32'(ifc.hcount), 32'(h));
      checkOutput("goto_v", 32'(ifc.vcount), 32'(v));
   endtask

   initial begin
      int lowCount, firstFall, secondFall, badCount, badPix, ftHigh;
      int ftPulses, ftFirst, ftSecond, ftWide, vsLow;
      logic prevH, prevF;
      logic [2:0] expRed;

      compared   = 0;
      mismatched = 0;
      ifcS.obj1_on = 1'b0; ifcS.obj1_rgb = 8'h00;
      ifcS.obj2_on = 1'b0; ifcS.obj2_rgb = 8'h00;
      ifcS.bg_rgb  = 8'h00;
      applyStimulus(1'b1, 8'hE0, 1'b1, 8'h1C, 8'h03);
      reset  = 1'b0;
      resetS = 1'b0;

      // Reset held for three clocks
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_hcount", 32'(ifc.hcount), 32'd0);
      checkOutput("rst_vcount", 32'(ifc.vcount), 32'd0);
      checkOutput("rst_rgb", 32'({ifc.red, ifc.green, ifc.blue}), 32'd0);
      checkOutput("rst_hsync", 32'(ifc.hsync), 32'd1);
      checkOutput("rst_vsync", 32'(ifc.vsync), 32'd1);
      checkOutput("rst_frame_tick", 32'(ifc.frame_tick), 32'd0);
      checkOutput("rst_pix_tick", 32'(ifc.pix_tick), 32'd0);

      reset = 1'b1;
      @(negedge clock);
      checkOutput("rel_tick_clk2", 32'(ifc.pix_tick), 32'd1);
      checkOutput("rel_hcount0", 32'(ifc.hcount), 32'd0);
      @(negedge clock);
      checkOutput("rel_tick_clk3", 32'(ifc.pix_tick), 32'd0);
      checkOutput("rel_hcount1", 32'(ifc.hcount), 32'd1);

      // Two lines free-running: tick k sits at pixel (k%800, k/800); outputs describe pixel k-1
      lowCount = 0; firstFall = -1; secondFall = -1; badCount = 0; badPix = 0; ftHigh = 0;
      prevH = 1'b1;
      for (int k = 1; k < 1600; k++) begin
         waitTick();
         if (ifc.hcount != 10'(k % 800) || ifc.vcount != 10'(k / 800)) badCount++;
         if (k < 800 && ifc.hsync == 1'b0) lowCount++;
         if (prevH == 1'b1 && ifc.hsync == 1'b0) begin
            if (firstFall < 0) firstFall = k;
            else if (secondFall < 0) secondFall = k;
         end
         prevH = ifc.hsync;
         if (ifc.frame_tick) ftHigh++;
         expRed = ((k % 800) >= 1 && (k % 800) <= 640) ? 3'd7 : 3'd0;
         if (ifc.red !== expRed || ifc.green !== 3'd0 || ifc.blue !== 2'd0) badPix++;
      end
      checkOutput("line_counter_seq", 32'(badCount), 32'd0);
      checkOutput("hsync_low_ticks", 32'(lowCount), 32'd96);
      checkOutput("hsync_first_fall", 32'(firstFall), 32'd657);
      checkOutput("hsync_period", 32'(secondFall - firstFall), 32'd800);
      checkOutput("line_pixels_obj1", 32'(badPix), 32'd0);
      checkOutput("line_no_frame_tick", 32'(ftHigh), 32'd0);

      // Layer priority on visible pixels of line 2
      gotoPixel(100, 2);
      applyStimulus(1'b1, 8'hE0, 1'b1, 8'h1C, 8'h03);
      waitTick();
      checkOutput("prio_obj1", 32'({ifc.red, ifc.green, ifc.blue}), 32'h0E0);
      applyStimulus(1'b0, 8'hE0, 1'b1, 8'h1C, 8'h03);
      waitTick();
      checkOutput("prio_obj2", 32'({ifc.red, ifc.green, ifc.blue}), 32'h01C);
      applyStimulus(1'b0, 8'hE0, 1'b0, 8'h1C, 8'h03);
      waitTick();
      checkOutput("prio_bg", 32'({ifc.red, ifc.green, ifc.blue}), 32'h003);

      // Right edge of the visible area, then deep in the horizontal blank
      gotoPixel(639, 2);
      applyStimulus(1'b1, 8'hFF, 1'b0, 8'h1C, 8'h03);
      waitTick();
      checkOutput("edge_last_visible", 32'({ifc.red, ifc.green, ifc.blue}), 32'h0FF);
      waitTick();
      checkOutput("edge_first_blank", 32'({ifc.red, ifc.green, ifc.blue}), 32'h000);
      gotoPixel(700, 2);
      waitTick();
      checkOutput("blank_h700_rgb", 32'({ifc.red, ifc.green, ifc.blue}), 32'h000);
      checkOutput("blank_h700_hsync", 32'(ifc.hsync), 32'd0);
      checkOutput("blank_h700_vsync", 32'(ifc.vsync), 32'd1);

      // Mid-line reset pulse
      gotoPixel(300, 3);
      checkOutput("pre_reset_rgb", 32'({ifc.red, ifc.green, ifc.blue}), 32'h0FF);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midrst_hcount", 32'(ifc.hcount), 32'd0);
      checkOutput("midrst_vcount", 32'(ifc.vcount), 32'd0);
      checkOutput("midrst_rgb", 32'({ifc.red, ifc.green, ifc.blue}), 32'd0);
      checkOutput("midrst_syncs", 32'({ifc.hsync, ifc.vsync}), 32'd3);
      checkOutput("midrst_pix_tick", 32'(ifc.pix_tick), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midrel_tick_clk2", 32'(ifc.pix_tick), 32'd1);
      checkOutput("midrel_hcount0", 32'(ifc.hcount), 32'd0);
      @(negedge clock);
      checkOutput("midrel_tick_clk3", 32'(ifc.pix_tick), 32'd0);
      checkOutput("midrel_hcount1", 32'(ifc.hcount), 32'd1);

      // Small instance: first pix_tick at clock 2, tick i at clock 2+3i, frame wraps at tick 55
      resetS = 1'b1;
      ftPulses = 0; ftFirst = -1; ftSecond = -1; ftWide = 0; vsLow = 0;
      prevF = 1'b0;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clock);
         if (ifcS.frame_tick) begin
            ftPulses++;
            if (ftFirst < 0) ftFirst = n;
            else if (ftSecond < 0) ftSecond = n;
            if (prevF) ftWide++;
         end
         prevF = ifcS.frame_tick;
         if (n >= 200 && n < 368 && ifcS.vsync == 1'b0) vsLow++;
      end
      checkOutput("frame_tick_first", 32'(ftFirst), 32'd167);
      checkOutput("frame_tick_period", 32'(ftSecond - ftFirst), 32'd168);
      checkOutput("frame_tick_count", 32'(ftPulses), 32'd2);
      checkOutput("frame_tick_width", 32'(ftWide), 32'd0);
      checkOutput("vsync_low_clocks", 32'(vsLow), 32'd48);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
